// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Brief    : Shared sequencer state encoding and instruction opcode match
//             constants used by the hazard unit and the control decoder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

    localparam logic [9:0]  c_OP_ADDI   = 10'b1001000100;
    localparam logic [10:0] c_OP_ADDS   = 11'b10101011000;
    localparam logic [10:0] c_OP_SUBS   = 11'b11101011000;
    localparam logic [10:0] c_OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR   = 11'b11111000000;
    localparam logic [10:0] c_OP_LSL    = 11'b11010011011;
    localparam logic [10:0] c_OP_LSR    = 11'b11010011010;
    localparam logic [10:0] c_OP_MUL    = 11'b10011011000;
    localparam logic [5:0]  c_MUL_SHAMT = 6'h1F;
    localparam logic [7:0]  c_OP_CBZ    = 8'b10110100;
    localparam logic [5:0]  c_OP_B      = 6'b000101;
    localparam logic [7:0]  c_OP_BCOND  = 8'b01010100;
    localparam logic [4:0]  c_COND_LT   = 5'b01011;
    localparam logic [4:0]  c_XZR       = 5'd31;

endpackage

`default_nettype wire

// File: rtl/pipe_src_decode.sv
// ============================================================================
//  Module   : pipe_src_decode
//  Brief    : Combinational source/destination classifier for the ID-stage
//             instruction, plus its register fields.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_src_decode
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr_d,
    output logic        reads_rn,
    output logic        reads_rm,
    output logic        reads_rt,
    output logic        writes_rd,
    output logic        is_load,
    output logic        is_mul,
    output logic        is_cbz,
    output logic [4:0]  rn,
    output logic [4:0]  rm,
    output logic [4:0]  rt
);

    logic [10:0] w_op11;

    assign w_op11 = instr_d[31:21];
    assign rn     = instr_d[9:5];
    assign rm     = instr_d[20:16];
    assign rt     = instr_d[4:0];

    // B, B.LT and the all-zero no-op fall through with every flag clear.
    always_comb begin
        reads_rn  = 1'b0;
        reads_rm  = 1'b0;
        reads_rt  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        is_mul    = 1'b0;
        is_cbz    = 1'b0;
        if (instr_d[31:22] == c_OP_ADDI) begin
            reads_rn  = 1'b1;
            writes_rd = 1'b1;
        end else if ((w_op11 == c_OP_ADDS) || (w_op11 == c_OP_SUBS)) begin
            reads_rn  = 1'b1;
            reads_rm  = 1'b1;
            writes_rd = 1'b1;
        end else if ((w_op11 == c_OP_MUL) && (instr_d[15:10] == c_MUL_SHAMT)) begin
            reads_rn  = 1'b1;
            reads_rm  = 1'b1;
            writes_rd = 1'b1;
            is_mul    = 1'b1;
        end else if ((w_op11 == c_OP_LDUR) && (instr_d[11:10] == 2'b00)) begin
            reads_rn  = 1'b1;
            writes_rd = 1'b1;
            is_load   = 1'b1;
        end else if (w_op11 == c_OP_STUR) begin
            reads_rn  = 1'b1;
            reads_rt  = 1'b1;
        end else if ((w_op11 == c_OP_LSL) || (w_op11 == c_OP_LSR)) begin
            reads_rn  = 1'b1;
            writes_rd = 1'b1;
        end else if (instr_d[31:24] == c_OP_CBZ) begin
            reads_rt  = 1'b1;
            is_cbz    = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard and stall sequencer: load-use and CBZ stalls, taken-branch
//             squash and front-end freeze while the multiplier occupies EX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        br_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        mul_start,
    output logic        mul_busy,
    output logic [15:0] stall_cycles
);

    localparam logic [3:0] c_CNT_LOAD = 4'(MUL_CYCLES - 1);

    logic        w_reads_rn, w_reads_rm, w_reads_rt, w_writes_rd;
    logic        w_is_load, w_is_mul, w_is_cbz;
    logic [4:0]  w_rn, w_rm, w_rt;

    state_e      r_state_q, w_state_d;
    logic [3:0]  r_cnt_q, w_cnt_d;
    logic        r_ex_valid_q, w_ex_valid_d;
    logic        r_ex_load_q, w_ex_load_d;
    logic        r_ex_wr_q, w_ex_wr_d;
    logic [4:0]  r_ex_rd_q, w_ex_rd_d;
    logic [15:0] r_stall_cycles_q, w_stall_cycles_d;

    logic        w_freeze, w_hit_any, w_load_use, w_cbz_haz, w_stall;

    pipe_src_decode u_src_decode (
        .instr_d   (instr_d),
        .reads_rn  (w_reads_rn),
        .reads_rm  (w_reads_rm),
        .reads_rt  (w_reads_rt),
        .writes_rd (w_writes_rd),
        .is_load   (w_is_load),
        .is_mul    (w_is_mul),
        .is_cbz    (w_is_cbz),
        .rn        (w_rn),
        .rm        (w_rm),
        .rt        (w_rt)
    );

    assign w_freeze   = (r_state_q == ST_MUL_WAIT) && (r_cnt_q != 4'd0);
    assign w_hit_any  = (w_reads_rn && (w_rn == r_ex_rd_q)) ||
                        (w_reads_rm && (w_rm == r_ex_rd_q)) ||
                        (w_reads_rt && (w_rt == r_ex_rd_q));
    assign w_load_use = r_ex_valid_q && r_ex_load_q && (r_ex_rd_q != c_XZR) && w_hit_any;
    // CBZ compares in ID, so any ALU result still in EX is too late for it.
    assign w_cbz_haz  = w_is_cbz && r_ex_valid_q && r_ex_wr_q &&
                        (r_ex_rd_q != c_XZR) && (w_rt == r_ex_rd_q);
    assign w_stall    = !w_freeze && (w_load_use || w_cbz_haz);

    assign mul_start    = (r_state_q == ST_MUL_WAIT) && (r_cnt_q == c_CNT_LOAD);
    assign mul_busy     = (r_state_q == ST_MUL_WAIT);
    assign stall_cycles = r_stall_cycles_q;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        if (w_freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
        end else if (w_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end else begin
            ifid_flush   = br_taken && !reset;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        if (w_freeze) begin
            w_cnt_d = r_cnt_q - 4'd1;
        end else if (w_is_mul && !w_stall) begin
            w_state_d = ST_MUL_WAIT;
            w_cnt_d   = c_CNT_LOAD;
        end else if (r_state_q == ST_MUL_WAIT) begin
            w_state_d = ST_RUN;
        end
    end

    always_comb begin
        w_ex_valid_d = r_ex_valid_q;
        w_ex_load_d  = r_ex_load_q;
        w_ex_wr_d    = r_ex_wr_q;
        w_ex_rd_d    = r_ex_rd_q;
        if (idex_write) begin
            if (idex_bubble) begin
                w_ex_valid_d = 1'b0;
                w_ex_load_d  = 1'b0;
                w_ex_wr_d    = 1'b0;
                w_ex_rd_d    = 5'd0;
            end else begin
                w_ex_valid_d = 1'b1;
                w_ex_load_d  = w_is_load;
                w_ex_wr_d    = w_writes_rd;
                w_ex_rd_d    = w_rt;
            end
        end
        w_stall_cycles_d = r_stall_cycles_q;
        if (!pc_write && (r_stall_cycles_q != 16'hFFFF)) begin
            w_stall_cycles_d = r_stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q        <= ST_RUN;
            r_cnt_q          <= 4'd0;
            r_ex_valid_q     <= 1'b0;
            r_ex_load_q      <= 1'b0;
            r_ex_wr_q        <= 1'b0;
            r_ex_rd_q        <= 5'd0;
            r_stall_cycles_q <= 16'd0;
        end else begin
            r_state_q        <= w_state_d;
            r_cnt_q          <= w_cnt_d;
            r_ex_valid_q     <= w_ex_valid_d;
            r_ex_load_q      <= w_ex_load_d;
            r_ex_wr_q        <= w_ex_wr_d;
            r_ex_rd_q        <= w_ex_rd_d;
            r_stall_cycles_q <= w_stall_cycles_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Scoreboard bench for pipe_hazard_ctrl driven by an instruction
//             stream and a behavioural pipeline occupancy model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int N = 4;

    typedef enum int {K_NOP, K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_LSL, K_LSR,
                      K_MUL, K_CBZ, K_B, K_BLT} kind_e;

    typedef struct {
        kind_e       kind;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        bit          br;
        logic [31:0] bits;
    } item_t;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_write;
        logic        idex_bubble;
        logic        exmem_bubble;
        logic        mul_start;
        logic        mul_busy;
        logic [15:0] stall_cycles;
    } exp_t;

    logic        clk, reset, br_taken;
    logic [31:0] instr_d;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        exmem_bubble, mul_start, mul_busy;
    logic [15:0] stall_cycles;

    pipe_hazard_ctrl #(.MUL_CYCLES(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_d      (instr_d),
        .br_taken     (br_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .mul_start    (mul_start),
        .mul_busy     (mul_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what sits in EX, how many frozen cycles the multiplier
    // still needs, and how many cycles the PC has been held.
    bit         m_ex_valid;
    kind_e      m_ex_kind;
    logic [4:0] m_ex_rd;
    bit         m_busy;
    int         m_left;
    bit         m_first;
    int         m_stalls;

    item_t      cur;
    item_t      prog[$];
    exp_t       sb[$];
    int         checks = 0;
    int         passes = 0;

    function automatic bit writes_k(kind_e k);
        return k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_LSL, K_LSR, K_MUL};
    endfunction

    function automatic bit reads_r(item_t it, logic [4:0] r);
        case (it.kind)
            K_ADDI, K_LDUR, K_LSL, K_LSR: return it.rn == r;
            K_ADDS, K_SUBS, K_MUL:        return (it.rn == r) || (it.rm == r);
            K_STUR:                       return (it.rn == r) || (it.rd == r);
            K_CBZ:                        return it.rd == r;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic item_t mk(kind_e k, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm, bit br);
        item_t       it;
        logic [11:0] i12;
        logic [8:0]  i9;
        logic [18:0] i19;
        logic [25:0] i26;
        logic [5:0]  sh;
        i12 = 12'($urandom);
        i9  = 9'($urandom);
        i19 = 19'($urandom);
        i26 = 26'($urandom);
        sh  = 6'($urandom);
        it.kind = k; it.rd = rd; it.rn = rn; it.rm = rm; it.br = br;
        case (k)
            K_ADDI:  it.bits = {10'b1001000100, i12, rn, rd};
            K_ADDS:  it.bits = {11'b10101011000, rm, 6'd0, rn, rd};
            K_SUBS:  it.bits = {11'b11101011000, rm, 6'd0, rn, rd};
            K_LDUR:  it.bits = {11'b11111000010, i9, 2'b00, rn, rd};
            K_STUR:  it.bits = {11'b11111000000, i9, 2'b00, rn, rd};
            K_LSL:   it.bits = {11'b11010011011, 5'd0, sh, rn, rd};
            K_LSR:   it.bits = {11'b11010011010, 5'd0, sh, rn, rd};
            K_MUL:   it.bits = {11'b10011011000, rm, 6'h1F, rn, rd};
            K_CBZ:   it.bits = {8'b10110100, i19, rd};
            K_B:     it.bits = {6'b000101, i26};
            K_BLT:   it.bits = {8'b01010100, i19, 5'b01011};
            default: it.bits = 32'h0;
        endcase
        return it;
    endfunction

    function automatic item_t nop();
        return mk(K_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    endfunction

    task automatic model_reset();
        m_ex_valid = 1'b0; m_ex_kind = K_NOP; m_ex_rd = 5'd0;
        m_busy = 1'b0; m_left = 0; m_first = 1'b0; m_stalls = 0;
    endtask

    task automatic model_eval(input item_t it, output exp_t e, output bit fz, output bit st);
        e = '0;
        e.pc_write = 1'b1; e.ifid_write = 1'b1; e.idex_write = 1'b1;
        fz = m_busy && (m_left > 0);
        st = 1'b0;
        if (fz) begin
            e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_write = 1'b0; e.exmem_bubble = 1'b1;
        end else begin
            st = m_ex_valid && (m_ex_rd != 5'd31) &&
                 (((m_ex_kind == K_LDUR) && reads_r(it, m_ex_rd)) ||
                  ((it.kind == K_CBZ) && writes_k(m_ex_kind) && (it.rd == m_ex_rd)));
            if (st) begin
                e.pc_write = 1'b0; e.ifid_write = 1'b0; e.idex_bubble = 1'b1;
            end else begin
                e.ifid_flush = it.br && !reset;
            end
        end
        e.mul_start    = m_first;
        e.mul_busy     = m_busy;
        e.stall_cycles = (m_stalls > 65535) ? 16'hFFFF : 16'(m_stalls);
    endtask

    task automatic model_update(input item_t it, input exp_t e, input bit fz, input bit st);
        if (reset) begin
            model_reset();
            return;
        end
        if (!e.pc_write) m_stalls++;
        if (fz) begin
            m_left--;
            m_first = 1'b0;
        end else begin
            if (st) m_ex_valid = 1'b0;
            else begin
                m_ex_valid = 1'b1; m_ex_kind = it.kind; m_ex_rd = it.rd;
            end
            if (!st && (it.kind == K_MUL)) begin
                m_busy = 1'b1; m_left = N - 1; m_first = 1'b1;
            end else begin
                m_busy = 1'b0; m_first = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        bit   fz, st;
        instr_d  = cur.bits;
        br_taken = cur.br;
        model_eval(cur, e, fz, st);
        sb.push_back(e);
        @(posedge clk);
        model_update(cur, e, fz, st);
        if (reset) cur = nop();
        else if (!e.ifid_write) cur = cur;
        else if (e.ifid_flush) cur = nop();
        else cur = (prog.size() > 0) ? prog.pop_front() : nop();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_write",     int'(pc_write),     int'(e.pc_write));
                chk("ifid_write",   int'(ifid_write),   int'(e.ifid_write));
                chk("ifid_flush",   int'(ifid_flush),   int'(e.ifid_flush));
                chk("idex_write",   int'(idex_write),   int'(e.idex_write));
                chk("idex_bubble",  int'(idex_bubble),  int'(e.idex_bubble));
                chk("exmem_bubble", int'(exmem_bubble), int'(e.exmem_bubble));
                chk("mul_start",    int'(mul_start),    int'(e.mul_start));
                chk("mul_busy",     int'(mul_busy),     int'(e.mul_busy));
                chk("stall_cycles", int'(stall_cycles), int'(e.stall_cycles));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] regs [4];
        int         budget;
        kind_e      k;
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
        reset = 1'b1; instr_d = 32'h0; br_taken = 1'b0;
        model_reset();
        cur = nop();
        @(posedge clk); #1;
        run(2);
        reset = 1'b0;
        run(2);

        // Load-use on X1, then a load to XZR which must not stall.
        prog.push_back(mk(K_LDUR, 5'd1, 5'd2, 5'd0, 1'b0));
        prog.push_back(mk(K_ADDS, 5'd3, 5'd1, 5'd4, 1'b0));
        prog.push_back(mk(K_LDUR, 5'd31, 5'd2, 5'd0, 1'b0));
        prog.push_back(mk(K_ADDS, 5'd3, 5'd31, 5'd4, 1'b0));
        // ALU result feeding CBZ, branch taken once the stall clears.
        prog.push_back(mk(K_ADDI, 5'd5, 5'd6, 5'd0, 1'b0));
        prog.push_back(mk(K_CBZ, 5'd5, 5'd0, 5'd0, 1'b1));
        run(12);

        // MUL with a taken branch waiting behind it during the freeze.
        prog.push_back(mk(K_MUL, 5'd6, 5'd7, 5'd8, 1'b0));
        prog.push_back(mk(K_B, 5'd0, 5'd0, 5'd0, 1'b1));
        run(10);

        // Back-to-back MULs.
        prog.push_back(mk(K_MUL, 5'd9, 5'd7, 5'd8, 1'b0));
        prog.push_back(mk(K_MUL, 5'd10, 5'd11, 5'd12, 1'b0));
        run(14);

        // Reset two cycles after a MUL is admitted.
        prog.push_back(mk(K_MUL, 5'd6, 5'd7, 5'd8, 1'b0));
        prog.push_back(mk(K_B, 5'd0, 5'd0, 5'd0, 1'b1));
        run(3);
        reset = 1'b1;
        model_reset();
        prog.delete();
        cur = nop();
        run(2);
        reset = 1'b0;
        run(8);

        for (int i = 0; i < 300; i++) begin
            k = kind_e'($urandom_range(0, 11));
            prog.push_back(mk(k, regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                              regs[$urandom_range(0, 3)],
                              (k inside {K_CBZ, K_B, K_BLT}) && ($urandom_range(0, 1) == 1)));
        end
        budget = 0;
        while ((prog.size() > 0) && (budget < 5000)) begin
            cycle();
            budget++;
        end
        chk("program_drained", prog.size(), 0);
        run(8);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
